// File: rtl/led_chaser.sv
// LED chaser: walking-light or bar-graph pattern across WIDTH outputs,
// advanced by an internal programmable prescaler.
module led_chaser #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DIV_W      = 32,
  parameter int unsigned ACTIVE_LOW = 1,
  parameter int unsigned POS_W      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic [POS_W-1:0] pos,
  output logic             step,
  output logic             wrap
);

  localparam logic       DIR_UP      = 1'b0;
  localparam logic       DIR_DOWN    = 1'b1;
  localparam logic [1:0] MODE_FWD    = 2'b00;
  localparam logic [1:0] MODE_REV    = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_FILL   = 2'b11;

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIDTH - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             tick_c;
  logic             wrap_cond_c;
  logic [WIDTH-1:0] lit_c;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      pos_q  <= '0;
      dir_q  <= DIR_UP;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  // Prescaler, position stepping and bounce direction
  always_comb begin
    cnt_d       = cnt_q;
    pos_d       = pos_q;
    dir_d       = dir_q;
    step_d      = 1'b0;
    wrap_d      = 1'b0;
    tick_c      = 1'b0;
    wrap_cond_c = 1'b0;

    if (clr) begin
      cnt_d = '0;
      pos_d = '0;
      dir_d = DIR_UP;
    end else begin
      // >= so that lowering div below the running count never stalls
      if (en) begin
        if (cnt_q >= div) begin
          cnt_d  = '0;
          tick_c = 1'b1;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      if (tick_c) begin
        case (mode)
          MODE_REV: begin
            wrap_cond_c = (pos_q == '0);
            pos_d       = wrap_cond_c ? POS_LAST : pos_q - POS_W'(1);
          end
          MODE_BOUNCE: begin
            if (dir_q == DIR_UP) begin
              if (pos_q == POS_LAST) begin
                wrap_cond_c = 1'b1;
                dir_d       = DIR_DOWN;
                pos_d       = POS_LAST - POS_W'(1);
              end else begin
                pos_d = pos_q + POS_W'(1);
              end
            end else begin
              if (pos_q == '0) begin
                wrap_cond_c = 1'b1;
                dir_d       = DIR_UP;
                pos_d       = POS_W'(1);
              end else begin
                pos_d = pos_q - POS_W'(1);
              end
            end
          end
          default: begin
            wrap_cond_c = (pos_q == POS_LAST);
            pos_d       = wrap_cond_c ? '0 : pos_q + POS_W'(1);
          end
        endcase
        step_d = 1'b1;
        wrap_d = wrap_cond_c;
      end

      // Entering bounce always starts upward
      if (mode != MODE_BOUNCE) begin
        dir_d = DIR_UP;
      end
    end
  end

  // Position p drives out bit WIDTH-1-p; fill mode lights positions 0..pos
  always_comb begin
    lit_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mode == MODE_FILL) begin
        lit_c[i] = (POS_W'(WIDTH - 1 - i) <= pos_q);
      end else begin
        lit_c[i] = (POS_W'(WIDTH - 1 - i) == pos_q);
      end
    end
  end

  assign out  = (ACTIVE_LOW != 0) ? ~lit_c : lit_c;
  assign pos  = pos_q;
  assign step = step_q;
  assign wrap = wrap_q;

  logic unused_mode_fwd;
  assign unused_mode_fwd = ^MODE_FWD;

endmodule

// File: tb/tb_led_chaser.sv
// Bench for led_chaser: three instances (16/active-low, 4/active-low,
// 5/active-high) checked every cycle against an arithmetic model plus literals.
module tb_led_chaser;

  localparam int W_OF  [3] = '{16, 4, 5};
  localparam int AL_OF [3] = '{1, 1, 0};

  logic        clk;
  logic        reset;
  logic        en_i   [3];
  logic        clr_i  [3];
  logic [31:0] div_i  [3];
  logic [1:0]  mode_i [3];

  logic [15:0] out0;
  logic [3:0]  out1;
  logic [4:0]  out2;
  logic [3:0]  pos0;
  logic [1:0]  pos1;
  logic [2:0]  pos2;
  logic        step_o [3];
  logic        wrap_o [3];

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: prescaler count, position, bounce phase, registered pulses
  longint m_cnt  [3];
  int     m_pos  [3];
  int     m_ph   [3];
  bit     m_step [3];
  bit     m_wrap [3];

  led_chaser #(.WIDTH(16), .DIV_W(32), .ACTIVE_LOW(1)) u0 (
    .clk(clk), .reset(reset), .en(en_i[0]), .clr(clr_i[0]), .div(div_i[0]),
    .mode(mode_i[0]), .out(out0), .pos(pos0), .step(step_o[0]), .wrap(wrap_o[0]));
  led_chaser #(.WIDTH(4), .DIV_W(32), .ACTIVE_LOW(1)) u1 (
    .clk(clk), .reset(reset), .en(en_i[1]), .clr(clr_i[1]), .div(div_i[1]),
    .mode(mode_i[1]), .out(out1), .pos(pos1), .step(step_o[1]), .wrap(wrap_o[1]));
  led_chaser #(.WIDTH(5), .DIV_W(32), .ACTIVE_LOW(0)) u2 (
    .clk(clk), .reset(reset), .en(en_i[2]), .clr(clr_i[2]), .div(div_i[2]),
    .mode(mode_i[2]), .out(out2), .pos(pos2), .step(step_o[2]), .wrap(wrap_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_out(input int w, input int al, input int p, input logic [1:0] md);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < w; k++) begin
      int pp;
      bit lit;
      pp   = w - 1 - k;
      lit  = (md == 2'b11) ? (pp <= p) : (pp == p);
      v[k] = lit ^ (al != 0);
    end
    return v;
  endfunction

  // Behavioural model: positions as modular arithmetic, bounce as a triangle wave
  always @(posedge clk or posedge reset) begin
    longint c;
    int     p, ph, w, per, r;
    bit     tk, wr;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_cnt[i]  <= 0;
        m_pos[i]  <= 0;
        m_ph[i]   <= 0;
        m_step[i] <= 1'b0;
        m_wrap[i] <= 1'b0;
      end else begin
        w  = W_OF[i];
        c  = m_cnt[i];
        p  = m_pos[i];
        ph = m_ph[i];
        tk = 1'b0;
        wr = 1'b0;
        if (clr_i[i]) begin
          c  = 0;
          p  = 0;
          ph = 0;
        end else begin
          if (en_i[i]) begin
            if (c >= longint'(div_i[i])) begin
              c  = 0;
              tk = 1'b1;
            end else begin
              c = c + 1;
            end
          end
          if (tk) begin
            case (mode_i[i])
              2'b01: begin
                wr = (p == 0);
                p  = (p + w - 1) % w;
              end
              2'b10: begin
                per = 2 * w - 2;
                wr  = (ph % per == w - 1) || (ph % per == 0 && ph > 0);
                ph  = ph + 1;
                r   = ph % per;
                p   = (r < w) ? r : per - r;
              end
              default: begin
                wr = (p == w - 1);
                p  = (p + 1) % w;
              end
            endcase
          end
        end
        if (mode_i[i] != 2'b10) ph = p;
        m_cnt[i]  <= c;
        m_pos[i]  <= p;
        m_ph[i]   <= ph;
        m_step[i] <= tk;
        m_wrap[i] <= wr;
      end
    end
  end

  // Every-cycle compare against the model
  always @(negedge clk) begin
    check("u0_out", {48'b0, out0}, exp_out(16, 1, m_pos[0], mode_i[0]));
    check("u0_pos", {60'b0, pos0}, 64'(m_pos[0]));
    check("u0_step", {63'b0, step_o[0]}, {63'b0, m_step[0]});
    check("u0_wrap", {63'b0, wrap_o[0]}, {63'b0, m_wrap[0]});
    check("u1_out", {60'b0, out1}, exp_out(4, 1, m_pos[1], mode_i[1]));
    check("u1_pos", {62'b0, pos1}, 64'(m_pos[1]));
    check("u1_step", {63'b0, step_o[1]}, {63'b0, m_step[1]});
    check("u1_wrap", {63'b0, wrap_o[1]}, {63'b0, m_wrap[1]});
    check("u2_out", {59'b0, out2}, exp_out(5, 0, m_pos[2], mode_i[2]));
    check("u2_pos", {61'b0, pos2}, 64'(m_pos[2]));
    check("u2_step", {63'b0, step_o[2]}, {63'b0, m_step[2]});
    check("u2_wrap", {63'b0, wrap_o[2]}, {63'b0, m_wrap[2]});
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
  endtask

  int          bnc_pos  [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
  int          bnc_wrap [8] = '{0, 0, 0, 1, 0, 0, 1, 0};
  logic [4:0]  fill_out [5] = '{5'b11000, 5'b11100, 5'b11110, 5'b11111, 5'b10000};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      en_i[i] = 1'b0; clr_i[i] = 1'b0; div_i[i] = '0; mode_i[i] = 2'b00;
    end
    edges(2);

    // Forward, div=0: one step per clock, wrap on return to 7FFF
    en_i[0] = 1'b1;
    reset   = 1'b0;
    check("fwd_reset_out", {48'b0, out0}, 64'h7FFF);
    check("fwd_reset_step", {63'b0, step_o[0]}, 64'd0);
    edges(1);
    check("fwd_first_out", {48'b0, out0}, 64'hBFFF);
    check("fwd_first_step", {63'b0, step_o[0]}, 64'd1);
    edges(14);
    check("fwd_last_out", {48'b0, out0}, 64'hFFFE);
    check("fwd_last_wrap", {63'b0, wrap_o[0]}, 64'd0);
    edges(1);
    check("fwd_wrap_out", {48'b0, out0}, 64'h7FFF);
    check("fwd_wrap_pulse", {63'b0, wrap_o[0]}, 64'd1);
    edges(1);
    check("fwd_wrap_end", {63'b0, wrap_o[0]}, 64'd0);

    // Reverse, div=3: one step per 4 clocks, first step 0 -> 15 with wrap
    div_i[0]  = 32'd3;
    mode_i[0] = 2'b01;
    pulse_reset();
    edges(3);
    check("rev_wait_pos", {60'b0, pos0}, 64'd0);
    edges(1);
    check("rev_first_pos", {60'b0, pos0}, 64'd15);
    check("rev_first_wrap", {63'b0, wrap_o[0]}, 64'd1);
    edges(1);
    check("rev_step_low", {63'b0, step_o[0]}, 64'd0);
    edges(3);
    check("rev_second_pos", {60'b0, pos0}, 64'd14);
    div_i[0] = 32'd9;
    edges(7);
    check("rev_cnt7_pos", {60'b0, pos0}, 64'd14);
    div_i[0] = 32'd2;
    edges(1);
    check("rev_div_drop_pos", {60'b0, pos0}, 64'd13);
    check("rev_div_drop_step", {63'b0, step_o[0]}, 64'd1);

    // Bounce on WIDTH=4
    en_i[0]   = 1'b0;
    en_i[1]   = 1'b1;
    mode_i[1] = 2'b10;
    pulse_reset();
    check("bnc_reset_pos", {62'b0, pos1}, 64'd0);
    for (int k = 0; k < 8; k++) begin
      edges(1);
      check($sformatf("bnc_pos_%0d", k), {62'b0, pos1}, 64'(bnc_pos[k]));
      check($sformatf("bnc_wrap_%0d", k), {63'b0, wrap_o[1]}, 64'(bnc_wrap[k]));
    end

    // Fill on WIDTH=5, active-high
    en_i[1]   = 1'b0;
    en_i[2]   = 1'b1;
    mode_i[2] = 2'b11;
    pulse_reset();
    check("fill_reset_out", {59'b0, out2}, 64'b10000);
    for (int k = 0; k < 5; k++) begin
      edges(1);
      check($sformatf("fill_out_%0d", k), {59'b0, out2}, {59'b0, fill_out[k]});
    end

    // Pause at pos 6 with cnt=1, then resume; clr at pos 9
    en_i[2]   = 1'b0;
    en_i[0]   = 1'b1;
    div_i[0]  = 32'd2;
    mode_i[0] = 2'b00;
    pulse_reset();
    edges(19);
    check("pause_start_pos", {60'b0, pos0}, 64'd6);
    en_i[0] = 1'b0;
    edges(10);
    check("pause_pos", {60'b0, pos0}, 64'd6);
    check("pause_out", {48'b0, out0}, 64'hFDFF);
    check("pause_step", {63'b0, step_o[0]}, 64'd0);
    en_i[0] = 1'b1;
    edges(1);
    check("resume_hold_pos", {60'b0, pos0}, 64'd6);
    edges(1);
    check("resume_pos", {60'b0, pos0}, 64'd7);
    check("resume_step", {63'b0, step_o[0]}, 64'd1);
    edges(6);
    check("clr_start_pos", {60'b0, pos0}, 64'd9);
    clr_i[0] = 1'b1;
    edges(1);
    check("clr_pos", {60'b0, pos0}, 64'd0);
    check("clr_wrap", {63'b0, wrap_o[0]}, 64'd0);
    check("clr_out", {48'b0, out0}, 64'h7FFF);
    clr_i[0] = 1'b0;

    // Async reset mid-sweep at pos 11, then bounce must move up
    div_i[0] = 32'd0;
    pulse_reset();
    edges(11);
    check("arst_start_pos", {60'b0, pos0}, 64'd11);
    #1;
    reset = 1'b1;
    #1;
    check("arst_out", {48'b0, out0}, 64'h7FFF);
    check("arst_step", {63'b0, step_o[0]}, 64'd0);
    check("arst_wrap", {63'b0, wrap_o[0]}, 64'd0);
    mode_i[0] = 2'b10;
    #2;
    reset = 1'b0;
    edges(1);
    check("arst_bnc_pos1", {60'b0, pos0}, 64'd1);
    check("arst_bnc_wrap", {63'b0, wrap_o[0]}, 64'd0);
    edges(1);
    check("arst_bnc_pos2", {60'b0, pos0}, 64'd2);
    edges(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_chaser.md
Name: led_chaser

Overview:
- Parametrised LED chaser: one-hot walking-light or bar-graph pattern across WIDTH outputs, stepped by a built-in programmable prescaler.
- Next generation of the fixed 16-LED walking-zero chaser: adds width, polarity, step rate, direction, bounce and fill modes, enable/pause, synchronous restart and position/wrap status.
- Sits between the board clock and the LED bank; needs no external clock divider.

Parameters:
- WIDTH, 16, number of LED outputs; legal range 2..64.
- DIV_W, 32, prescaler counter and div port width.
- ACTIVE_LOW, 1, when 1 a lit LED drives 0 and unlit LEDs drive 1; when 0, polarity is inverted.
- POS_W, $clog2(WIDTH), width of pos; derived, not overridden.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- en  in  1  step enable; 0 pauses the prescaler and position.
- clr  in  1  synchronous restart to position 0.
- div  in  DIV_W  prescaler terminal value; one step every div+1 clocks.
- mode  in  2  00 forward, 01 reverse, 10 bounce, 11 fill.
- out  out  WIDTH  LED drive.
- pos  out  POS_W  current position, 0..WIDTH-1.
- step  out  1  one-clock pulse on each position update.
- wrap  out  1  one-clock pulse on an end-of-sweep update.

Behaviour:
- Position mapping: position p corresponds to out bit WIDTH-1-p, so pos 0 is the MSB.
- Reset (async): cnt=0, pos=0, dir=up, step=0, wrap=0.
- Reset value of out: bit WIDTH-1 lit, all others unlit (ACTIVE_LOW=1, WIDTH=16: 16'h7FFF).
- Prescaler, when en=1: if cnt>=div, then cnt<=0 and a tick is internal-high this cycle; else cnt<=cnt+1.
- The >= compare ensures that lowering div mid-count never stalls. div=0 gives a tick every clock.
- en=0: cnt, pos and dir hold; no tick.
- clr=1 (priority over en and tick): cnt<=0, pos<=0, dir<=up, step<=0, wrap<=0.
- On a tick, in the same clock edge:
  - forward/fill: pos<=(pos==WIDTH-1)?0:pos+1; the wrap condition is pos==WIDTH-1.
  - reverse: pos<=(pos==0)?WIDTH-1:pos-1; the wrap condition is pos==0.
  - bounce, dir=up: if pos==WIDTH-1, then dir<=down, pos<=WIDTH-2, wrap condition true; else pos+1.
  - bounce, dir=down: if pos==0, then dir<=up, pos<=1, wrap condition true; else pos-1.
  - Endpoints are shown for one step only, with no dwell.
- step and wrap are registered: step<=tick and wrap<=tick&&wrap condition. Both go high in the same cycle pos shows the new value and last exactly one clock.
- dir is forced to up on every clock where mode!=10, so entering bounce always starts upward.
- A mode change never alters pos. The new stepping rule applies from the next tick.
- out is a combinational decode of pos and mode, valid the same cycle pos changes:
  - modes 00/01/10: only the LED at pos is lit.
  - mode 11: LEDs at positions 0..pos are lit (bar graph).
- pos is always in 0..WIDTH-1. Non-power-of-two WIDTH must wrap at WIDTH-1, not at 2^POS_W-1.
- Reset asserted mid-sweep returns all state to reset values immediately. After deassertion the first tick occurs div+1 enabled clocks later.

Test Plan:
- WIDTH=16, ACTIVE_LOW=1, div=0, mode=00, en=1 -> out steps 7FFF, BFFF, DFFF, ..., FFFE, 7FFF, one value per clock. wrap pulses once, in the cycle out returns to 7FFF. step is high every cycle after the first.
- div=3, mode=01 -> exactly one step per 4 clocks. The first step after reset goes from pos 0 to pos 15, with wrap=1. Changing div from 9 to 2 while cnt=7 produces a tick on the next clock.
- WIDTH=4, mode=10, div=0 -> pos sequence 0,1,2,3,2,1,0,1,2. wrap pulses on the updates to 2 (after 3) and to 1 (after 0).
- WIDTH=5, ACTIVE_LOW=0, mode=11 -> out 10000, 11000, 11100, 11110, 11111, 10000. pos never exceeds 4.
- en=0 for 10 clocks at pos=6 -> pos, out and cnt frozen; no step. After en returns to 1, stepping resumes with the cnt value intact. clr pulse at pos=9 -> pos=0 next clock, with no wrap pulse.
- reset asserted asynchronously between clock edges at pos=11 -> out=7FFF, step=0, wrap=0 immediately, without waiting for a clock. Bounce after reset starts moving upward.
